// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver.
//
// This block takes its s_tick strobe from the baud-rate generator. The
// generator divisor is f_clk/(16*baud) - 1.
//
// Each frame has one start bit, DBIT data bits sent LSB first, and a stop
// period of SB_TICK ticks. The received byte is presented with a one-cycle
// done strobe and a framing-error flag.
//
// Parameters
//   DBIT     data bits per frame, 5..8
//   SB_TICK  stop period in s_ticks (16/24/32 = 1/1.5/2 stop bits)
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   rx            serial line, asynchronous to clk, idles high
//   s_tick        one-clk oversample enable, 16 per bit period
//   dout          last received byte, right-aligned, upper bits zero
//   rx_done_tick  one-clk pulse; dout/frame_err update on the same edge
//   frame_err     stop sample of the last frame was 0; held until next frame
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line idle; waiting for rx_s low (s_tick ignored)
// START | counting to mid start bit; confirm or reject as a glitch
// DATA  | sampling a data bit every 16 ticks, shifting LSB first
// STOP  | waiting out the stop period; sample stop level and strobe

module uart_rx_os #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [4:0] START_MID = 5'd7;
  localparam logic [4:0] BIT_END   = 5'd15;
  localparam logic [4:0] STOP_END  = 5'(SB_TICK - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DBIT - 1);
  // Bits enter at the MSB of the shift register, so a short frame ends up
  // left-aligned and must be shifted down before it is presented.
  localparam int         ALIGN_SH  = 8 - DBIT;

  // Two-flop synchronizer. It resets to the idle line level so that reset
  // release cannot look like a start bit.
  logic rx_meta_q;
  logic rx_s_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  state_t     state_q;
  logic [4:0] s_cnt_q;
  logic [2:0] n_cnt_q;
  logic [7:0] b_reg_q;
  logic [7:0] dout_q;
  logic       frame_err_q;
  logic       done_q;

  logic [7:0] b_shift_d;
  logic [7:0] b_aligned_d;

  assign b_shift_d   = {rx_s_q, b_reg_q[7:1]};
  assign b_aligned_d = b_reg_q >> ALIGN_SH;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      s_cnt_q     <= 5'd0;
      n_cnt_q     <= 3'd0;
      b_reg_q     <= 8'h00;
      dout_q      <= 8'h00;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            s_cnt_q <= 5'd0;
          end
        end

        START: begin
          if (s_tick) begin
            if (s_cnt_q == START_MID) begin
              if (!rx_s_q) begin
                state_q <= DATA;
                s_cnt_q <= 5'd0;
                n_cnt_q <= 3'd0;
              end else begin
                // The line went back high before mid start bit: a glitch.
                state_q <= IDLE;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 5'd1;
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (s_cnt_q == BIT_END) begin
              s_cnt_q <= 5'd0;
              b_reg_q <= b_shift_d;
              if (n_cnt_q == LAST_BIT) begin
                state_q <= STOP;
              end else begin
                n_cnt_q <= n_cnt_q + 3'd1;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 5'd1;
            end
          end
        end

        STOP: begin
          if (s_tick) begin
            if (s_cnt_q == STOP_END) begin
              // Data is delivered even when the stop level is wrong.
              dout_q      <= b_aligned_d;
              frame_err_q <= ~rx_s_q;
              done_q      <= 1'b1;
              state_q     <= IDLE;
            end else begin
              s_cnt_q <= s_cnt_q + 5'd1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout         = dout_q;
  assign frame_err    = frame_err_q;
  assign rx_done_tick = done_q;

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

UART receiver sitting directly downstream of the baud-rate tick generator. It consumes that block's one-cycle `s_tick` pulse at 16× the baud rate and oversamples the asynchronous `rx` line. It recovers frames made of 1 start bit, DBIT data bits (LSB first) and a stop period, then presents each byte with a one-cycle done strobe and a framing-error flag. The generator divisor for this use is f_clk/(16·baud) − 1.

## Interface
- `DBIT`, 8: data bits per frame; legal range 5–8.
- `SB_TICK`, 16: stop-period length in s_ticks; 16/24/32 give 1/1.5/2 stop bits.

- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `rx` input 1: serial line, asynchronous to `clk`, idles high.
- `s_tick` input 1: oversample enable from the baud generator, one `clk` wide, 16 per bit period.
- `dout` output 8: last received byte; `dout[DBIT-1:0]` is the data, upper bits are 0.
- `rx_done_tick` output 1: one-cycle pulse; `dout`/`frame_err` are updated on the same edge.
- `frame_err` output 1: stop-period sample of the last frame was 0; held until the next frame completes.

## Operation
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer (`rx_s`), reset value 1. All decisions use `rx_s`.
- **Registers:**
  - `state`: IDLE / START / DATA / STOP.
  - `s_cnt`: 5-bit tick counter.
  - `n_cnt`: 3-bit bit counter.
  - `b_reg`: 8-bit shift register.
- **IDLE:** if `rx_s`==0, go to START and clear `s_cnt`. `s_tick` is ignored in IDLE.
- **START:** on each `s_tick`:
  - if `s_cnt`==7 (mid start bit): if `rx_s`==0, go to DATA with `s_cnt`=0 and `n_cnt`=0; otherwise return to IDLE (glitch rejected, no strobe).
  - else increment `s_cnt`.
- **DATA:** on each `s_tick`:
  - if `s_cnt`==15: clear `s_cnt` and shift `b_reg` ← {`rx_s`, `b_reg[7:1]`}. If `n_cnt`==DBIT−1, go to STOP; otherwise increment `n_cnt`.
  - else increment `s_cnt`.
- **STOP:** on each `s_tick`:
  - if `s_cnt`==SB_TICK−1: load `dout` ← `b_reg` >> (8−DBIT), load `frame_err` ← ~`rx_s`, set `rx_done_tick`, go to IDLE.
  - else increment `s_cnt`.
- A framing error does not suppress the strobe; the data is still delivered.
- Counters advance only on `s_tick` cycles; cycles without `s_tick` hold all state (except the IDLE start detect).
- Reset mid-frame aborts the frame: no strobe, `dout` and `frame_err` return to 0.
- If a low `rx_s` is already present on the IDLE cycle after STOP, a new START begins immediately (back-to-back frames).

## Timing
- Reset values: `state`=IDLE, `s_cnt`=0, `n_cnt`=0, `b_reg`=0, `dout`=0x00, `frame_err`=0, `rx_done_tick`=0, sync flops=1.
- `rx` falling edge to START entry: 3 `clk` edges (2 sync + 1 state).
- Data bit k is sampled on the 16th `s_tick` after the previous sample. Start is confirmed on the 8th tick, so each sample lands near mid-bit.
- `rx_done_tick` is registered and high for exactly one `clk`, in the cycle after the edge where STOP sees `s_tick` with `s_cnt`==SB_TICK−1.
- `dout` and `frame_err` change only on that edge and are stable otherwise.
- Total frame-to-strobe time: 8 + 16·DBIT + SB_TICK ticks after START entry, plus 1 `clk`.

## Test plan
- **Basic receive:** baud generator with dvsr=325 (100 MHz, 19200 baud); send 0x55 with 1 stop bit → one `rx_done_tick`, `dout`=0x55, `frame_err`=0, stays in IDLE afterwards.
- **Glitch rejection:** `rx` low for only 4 s_ticks, then high → START returns to IDLE; no strobe; `dout` unchanged.
- **Framing error:** send 0xA3 with the stop bit driven 0 → strobe fires, `dout`=0xA3, `frame_err`=1. Then send 0x0F correctly → `frame_err`=0.
- **Back-to-back:** send 0x00, 0xFF, 0x81 with no idle gap → exactly 3 strobes, data in order.
- **Reset mid-frame:** assert `reset`=0 asynchronously (between clock edges) during data bit 3 → outputs immediately 0 and state IDLE. Release reset, then send 0x3C → `dout`=0x3C.
- **Parameter variant:** DBIT=7, SB_TICK=32; send 0x5A (7-bit) → `dout`=0x5A with bit 7 = 0. Strobe occurs 8+112+32 ticks after START entry.
